// File: rtl/rv32im_icache_assoc_pkg.sv
// Shared widths, address-field positions and controller state encoding for
// the set-associative instruction cache.
package rv32im_icache_assoc_pkg;

    localparam int XLEN             = 32;
    localparam int ILEN             = 32;
    localparam int LINE_LEN         = 2;
    localparam int SET_LEN          = 2;
    localparam int WAY_LEN          = 1;
    localparam int UNUSED_ADDR_BITS = 10;

    localparam int WORDS     = 1 << LINE_LEN;
    localparam int SETS      = 1 << SET_LEN;
    localparam int WAYS      = 1 << WAY_LEN;
    localparam int TAG_WIDTH = XLEN - 2 - LINE_LEN - SET_LEN - UNUSED_ADDR_BITS;
    localparam int RAM_AW    = WAY_LEN + SET_LEN + LINE_LEN;

    localparam int OFF_LO = 2;
    localparam int OFF_HI = LINE_LEN + 1;
    localparam int IDX_LO = LINE_LEN + 2;
    localparam int IDX_HI = SET_LEN + LINE_LEN + 1;
    localparam int TAG_LO = IDX_HI + 1;
    localparam int TAG_HI = XLEN - 1 - UNUSED_ADDR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_FILL   = 3'd2,
        ST_FINISH = 3'd3,
        ST_REPLY  = 3'd4
    } state_e;

    // Data RAM word address: way selects the bank, then set, then word in line.
    function automatic logic [RAM_AW-1:0] ram_addr(input logic [WAY_LEN-1:0]  way,
                                                    input logic [SET_LEN-1:0]  idx,
                                                    input logic [LINE_LEN-1:0] off);
        return {way, idx, off};
    endfunction

endpackage

// File: rtl/rv32im_icache_assoc_bram.sv
// Simple dual-port block RAM: one write port, one read port with read enable
// and a registered read output (one-cycle read latency).
module bram_dual_re #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Write on we_i, registered read on re_i; no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/rv32im_icache_assoc.sv
// Set-associative instruction cache between fetch and the Wishbone arbiter.
// Line refill over classic Wishbone reads, per-set round-robin replacement,
// fence.i flush and fault reporting for misaligned fetches / bus errors.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | accept fetches; hits and misaligned faults answered next cycle
// ARB    | miss pending, ctrl_req_o raised, waiting for ctrl_grant_i
// FILL   | Wishbone cycle open, one word written per ack_i
// FINISH | tag/valid/victim update, RAM read of the requested word
// REPLY  | instruction returned; not busy, so a new fetch is accepted
module rv32im_icache_assoc
    import rv32im_icache_assoc_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              fetch_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic              flush_i,
    output logic [ILEN-1:0]   instruction_o,
    output logic              valid_o,
    output logic              fault_o,
    output logic              busy_o,
    output logic              ctrl_req_o,
    input  logic              ctrl_grant_i,
    input  logic [XLEN-1:0]   master_dat_i,
    input  logic              ack_i,
    input  logic              err_i,
    output logic [XLEN-3:0]   adr_o,
    output logic [3:0]        sel_o,
    output logic              stb_o,
    output logic              cyc_o
);

    state_e state_q, state_d;

    logic [LINE_LEN-1:0]  req_off;
    logic [SET_LEN-1:0]   req_idx;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 unused_addr_hi;
    logic                 misaligned;
    logic                 accept;
    logic                 hit_raw;
    logic [WAY_LEN-1:0]   hit_way;
    logic                 hit_take;
    logic                 miss_take;
    logic                 fault_take;
    logic                 fill_beat;
    logic                 fill_err;

    logic [WAYS-1:0][SETS-1:0] valid_q;
    logic [TAG_WIDTH-1:0]      tag_q    [0:WAYS-1][0:SETS-1];
    logic [WAY_LEN-1:0]        victim_q [0:SETS-1];

    logic [TAG_WIDTH-1:0] lat_tag;
    logic [SET_LEN-1:0]   lat_idx;
    logic [LINE_LEN-1:0]  lat_off;
    logic [WAY_LEN-1:0]   fill_way_q;
    logic [LINE_LEN-1:0]  word_q;
    logic                 flush_pend_q;
    logic                 resp_q;
    logic                 fault_q;

    logic                 ram_we;
    logic [RAM_AW-1:0]    ram_waddr;
    logic                 ram_re;
    logic [RAM_AW-1:0]    ram_raddr;
    logic [XLEN-1:0]      ram_rdata;

    assign req_off        = addr_i[OFF_HI:OFF_LO];
    assign req_idx        = addr_i[IDX_HI:IDX_LO];
    assign req_tag        = addr_i[TAG_HI:TAG_LO];
    assign unused_addr_hi = ^addr_i[XLEN-1:TAG_HI+1];
    assign misaligned     = (addr_i[1:0] != 2'b00);

    // REPLY is not busy, so it takes a new fetch exactly like IDLE.
    assign accept     = (state_q == ST_IDLE) || (state_q == ST_REPLY);
    assign fault_take = accept && fetch_i && misaligned;
    // A flush in the same cycle invalidates everything, so the fetch must miss.
    assign hit_take   = accept && fetch_i && !misaligned && hit_raw && !flush_i;
    assign miss_take  = accept && fetch_i && !misaligned && !(hit_raw && !flush_i);
    assign fill_err   = (state_q == ST_FILL) && err_i;
    assign fill_beat  = (state_q == ST_FILL) && ack_i && !err_i;

    // Tag compare across ways; descending scan so the lowest matching way wins.
    always_comb begin
        hit_raw = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[WAY_LEN'(w)][req_idx] && (tag_q[WAY_LEN'(w)][req_idx] == req_tag)) begin
                hit_raw = 1'b1;
                hit_way = WAY_LEN'(w);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a bus error abandons the line and returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_REPLY: state_d = miss_take ? ST_ARB : ST_IDLE;
            ST_ARB:            if (ctrl_grant_i) state_d = ST_FILL;
            ST_FILL: begin
                if (err_i) begin
                    state_d = ST_IDLE;
                end else if (ack_i && (&word_q)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH:         state_d = ST_REPLY;
            default:           state_d = ST_IDLE;
        endcase
    end

    // Bus, handshake and RAM port outputs decoded from the current state.
    always_comb begin
        busy_o     = (state_q == ST_ARB) || (state_q == ST_FILL) || (state_q == ST_FINISH);
        ctrl_req_o = (state_q == ST_ARB) || (state_q == ST_FILL);
        cyc_o      = (state_q == ST_FILL);
        stb_o      = (state_q == ST_FILL);
        sel_o      = 4'b1111;
        adr_o      = '0;
        if (state_q == ST_FILL) begin
            adr_o = {{UNUSED_ADDR_BITS{1'b0}}, lat_tag, lat_idx, word_q};
        end
        valid_o    = resp_q || (state_q == ST_REPLY);
        fault_o    = fault_q;
        ram_we     = fill_beat;
        ram_waddr  = ram_addr(fill_way_q, lat_idx, word_q);
        ram_re     = hit_take || (state_q == ST_FINISH);
        ram_raddr  = ram_addr(hit_way, req_idx, req_off);
        if (state_q == ST_FINISH) begin
            ram_raddr = ram_addr(fill_way_q, lat_idx, lat_off);
        end
    end

    // Miss bookkeeping, valid bits, replacement pointers and response pulses.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q      <= '0;
            lat_tag      <= '0;
            lat_idx      <= '0;
            lat_off      <= '0;
            fill_way_q   <= '0;
            word_q       <= '0;
            flush_pend_q <= 1'b0;
            resp_q       <= 1'b0;
            fault_q      <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                victim_q[s] <= '0;
            end
        end else begin
            resp_q  <= hit_take || fault_take || fill_err;
            fault_q <= fault_take || fill_err;

            if (miss_take) begin
                lat_tag      <= req_tag;
                lat_idx      <= req_idx;
                lat_off      <= req_off;
                fill_way_q   <= victim_q[req_idx];
                word_q       <= '0;
                flush_pend_q <= 1'b0;
            end else if (busy_o && flush_i) begin
                flush_pend_q <= 1'b1;
            end

            if (fill_beat) begin
                word_q <= word_q + LINE_LEN'(1);
            end

            // The victim way is invalidated as soon as its RAM starts being
            // overwritten, so an aborted fill never leaves a stale-valid line.
            if (flush_i) begin
                valid_q <= '0;
            end else if (miss_take) begin
                valid_q[victim_q[req_idx]][req_idx] <= 1'b0;
            end else if ((state_q == ST_FINISH) && !flush_pend_q) begin
                valid_q[fill_way_q][lat_idx] <= 1'b1;
            end

            if (state_q == ST_FINISH) begin
                victim_q[lat_idx] <= fill_way_q + WAY_LEN'(1);
            end
        end
    end

    // Tag store; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_FINISH) begin
            tag_q[fill_way_q][lat_idx] <= lat_tag;
        end
    end

    bram_dual_re #(
        .ADDR_WIDTH (RAM_AW),
        .DATA_WIDTH (XLEN)
    ) u_data_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (master_dat_i),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign instruction_o = ram_rdata[ILEN-1:0];

endmodule

// File: tb/tb_rv32im_icache_assoc.sv
// Self-checking bench for rv32im_icache_assoc: randomized fetch streams and bus
// timing checked against a behavioural cache model kept in plain arrays.
module tb_rv32im_icache_assoc;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        fetch_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] instruction_o;
    logic        valid_o, fault_o, busy_o, ctrl_req_o;
    logic        ctrl_grant_i = 1'b0;
    logic [31:0] master_dat_i = '0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [29:0] adr_o;
    logic [3:0]  sel_o;
    logic        stb_o, cyc_o;

    rv32im_icache_assoc dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .fetch_i       (fetch_i),
        .addr_i        (addr_i),
        .flush_i       (flush_i),
        .instruction_o (instruction_o),
        .valid_o       (valid_o),
        .fault_o       (fault_o),
        .busy_o        (busy_o),
        .ctrl_req_o    (ctrl_req_o),
        .ctrl_grant_i  (ctrl_grant_i),
        .master_dat_i  (master_dat_i),
        .ack_i         (ack_i),
        .err_i         (err_i),
        .adr_o         (adr_o),
        .sel_o         (sel_o),
        .stb_o         (stb_o),
        .cyc_o         (cyc_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] seed;

    // Behavioural model: 4 sets x 2 ways, round-robin pointer per set.
    bit          m_valid [4][2];
    logic [15:0] m_tag   [4][2];
    int          m_rr    [4];

    // Per-fetch expectations and observations.
    bit          e_miss, e_fault, e_err;
    logic [31:0] e_instr;
    bit          o_valid, o_fault, o_miss, o_busy;
    logic [31:0] o_instr;
    int          o_lat;
    logic [29:0] adr_log [$];
    bit          stb_seen;

    always @(negedge clk_i) if (stb_o) stb_seen = 1'b1;

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E3779B1) ^ seed;
    endfunction

    function automatic logic [29:0] word_of(input logic [31:0] a);
        return {10'b0, a[21:2]};
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s;
        s = int'(a[5:4]);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[21:6]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic m_reset();
        m_clear();
        for (int s = 0; s < 4; s++) m_rr[s] = 0;
    endtask

    task automatic m_update(input logic [31:0] a, input bit fw, input bit er, input bit fm);
        int s;
        s = int'(a[5:4]);
        if (fw) m_clear();
        if (a[1:0] != 2'b00) return;
        if (m_hit(a)) return;
        m_valid[s][m_rr[s]] = 1'b0;
        if (fm) m_clear();
        if (er) return;
        if (!fm) begin
            m_valid[s][m_rr[s]] = 1'b1;
            m_tag[s][m_rr[s]]   = a[21:6];
        end
        m_rr[s] = (m_rr[s] + 1) % 2;
    endtask

    // Predicts one fetch from the model, drives it (acting as arbiter and
    // Wishbone slave on a miss) and records what the cache did.
    task automatic do_fetch(input logic [31:0] a, input int err_beat, input int flush_beat,
                            input bit flush_with);
        int  beat, last_beat, cnt;
        bit  mis, fl_mid;
        mis       = (a[1:0] != 2'b00);
        e_miss    = !mis && (flush_with || !m_hit(a));
        e_err     = e_miss && err_beat >= 0 && err_beat < 4;
        e_fault   = mis || e_err;
        last_beat = e_err ? err_beat : 3;
        fl_mid    = e_miss && flush_beat >= 0 && flush_beat <= last_beat;
        e_instr   = mem_word(word_of(a));
        m_update(a, flush_with, e_err, fl_mid);

        adr_log.delete();
        stb_seen = 1'b0;
        o_valid = 0; o_fault = 0; o_miss = 0; o_busy = 0; o_instr = '0; o_lat = 0;

        fetch_i = 1'b1; addr_i = a; flush_i = flush_with;
        @(negedge clk_i);
        fetch_i = 1'b0; flush_i = 1'b0; addr_i = $urandom;
        o_miss = ctrl_req_o;
        if (ctrl_req_o) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            ctrl_grant_i = 1'b1;
            @(negedge clk_i);
            beat = 0;
            while (cyc_o && beat < 8) begin
                if (beat == flush_beat) begin
                    flush_i = 1'b1;
                    @(negedge clk_i);
                    flush_i = 1'b0;
                end
                repeat ($urandom_range(0, 2)) @(negedge clk_i);
                adr_log.push_back(adr_o);
                master_dat_i = mem_word(adr_o);
                err_i = (beat == err_beat);
                ack_i = !err_i;
                @(negedge clk_i);
                ack_i = 1'b0; err_i = 1'b0; master_dat_i = $urandom;
                beat++;
            end
            ctrl_grant_i = 1'b0;
        end
        cnt = 0;
        while (!valid_o && cnt < 20) begin
            @(negedge clk_i);
            cnt++;
        end
        o_lat   = cnt + 1;
        o_valid = valid_o;
        o_fault = fault_o;
        o_instr = instruction_o;
        o_busy  = busy_o;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_checks++; if (valid_o !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_checks++; if (fault_o !== 1'b0)    begin n_fail++; $display("FAIL reset_fault got %b want 0", fault_o); end
        n_checks++; if (busy_o !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (ctrl_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", ctrl_req_o); end
        n_checks++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_bus cyc %b stb %b want 0 0", cyc_o, stb_o); end
        n_checks++; if (adr_o !== 30'h0)     begin n_fail++; $display("FAIL reset_adr got %h want 0", adr_o); end
        n_checks++; if (sel_o !== 4'hF)      begin n_fail++; $display("FAIL reset_sel got %h want f", sel_o); end
        reset_i = 1'b0;
        m_reset();
        @(negedge clk_i);
    endtask

    task automatic test_cold_miss();
        do_fetch(32'h100, -1, -1, 1'b0);
        n_checks++; if (o_miss !== 1'b1)  begin n_fail++; $display("FAIL cold_req got %b want 1", o_miss); end
        n_checks++; if (adr_log.size() != 4) begin n_fail++; $display("FAIL cold_beats got %0d want 4", adr_log.size()); end
        for (int i = 0; i < adr_log.size(); i++) begin
            n_checks++;
            if (adr_log[i] !== 30'h40 + 30'(i)) begin n_fail++; $display("FAIL cold_adr[%0d] got %h want %h", i, adr_log[i], 30'h40 + 30'(i)); end
        end
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL cold_valid got %b want 1", o_valid); end
        n_checks++; if (o_instr !== mem_word(30'h40)) begin n_fail++; $display("FAIL cold_instr got %h want %h", o_instr, mem_word(30'h40)); end
        n_checks++; if (o_busy !== 1'b0 || o_fault !== 1'b0) begin n_fail++; $display("FAIL cold_busy_fault got %b %b want 0 0", o_busy, o_fault); end
    endtask

    task automatic test_hits();
        logic [31:0] a;
        for (int i = 1; i < 4; i++) begin
            a = 32'h100 + 32'(4 * i);
            do_fetch(a, -1, -1, 1'b0);
            n_checks++; if (o_miss !== 1'b0) begin n_fail++; $display("FAIL hit_req@%h got %b want 0", a, o_miss); end
            n_checks++; if (o_lat != 1 || o_valid !== 1'b1) begin n_fail++; $display("FAIL hit_lat@%h got %0d valid %b want 1 1", a, o_lat, o_valid); end
            n_checks++; if (o_instr !== e_instr) begin n_fail++; $display("FAIL hit_instr@%h got %h want %h", a, o_instr, e_instr); end
        end
    endtask

    task automatic test_replacement();
        logic [31:0] seq [4] = '{32'h140, 32'h180, 32'h140, 32'h100};
        bit          want_miss [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_fetch(seq[i], -1, -1, 1'b0);
            n_checks++; if (o_miss !== want_miss[i]) begin n_fail++; $display("FAIL repl_miss@%h got %b want %b", seq[i], o_miss, want_miss[i]); end
            n_checks++; if (o_instr !== e_instr || o_valid !== 1'b1) begin n_fail++; $display("FAIL repl_instr@%h got %h want %h", seq[i], o_instr, e_instr); end
        end
    endtask

    task automatic test_bus_error();
        do_fetch(32'h200, 1, -1, 1'b0);
        n_checks++; if (o_valid !== 1'b1 || o_fault !== 1'b1) begin n_fail++; $display("FAIL err_fault valid %b fault %b want 1 1", o_valid, o_fault); end
        n_checks++; if (adr_log.size() != 2) begin n_fail++; $display("FAIL err_beats got %0d want 2", adr_log.size()); end
        n_checks++; if (cyc_o !== 1'b0 || ctrl_req_o !== 1'b0) begin n_fail++; $display("FAIL err_release cyc %b req %b want 0 0", cyc_o, ctrl_req_o); end
        do_fetch(32'h200, -1, -1, 1'b0);
        n_checks++; if (o_miss !== 1'b1) begin n_fail++; $display("FAIL err_refetch_miss got %b want 1", o_miss); end
        n_checks++; if (o_fault !== 1'b0 || o_instr !== e_instr) begin n_fail++; $display("FAIL err_refetch fault %b instr %h want 0 %h", o_fault, o_instr, e_instr); end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h103, 32'h146};
        for (int i = 0; i < 4; i++) begin
            do_fetch(addrs[i], -1, -1, 1'b0);
            n_checks++; if (o_valid !== 1'b1 || o_fault !== 1'b1 || o_lat != 1) begin n_fail++; $display("FAIL mis@%h valid %b fault %b lat %0d want 1 1 1", addrs[i], o_valid, o_fault, o_lat); end
            n_checks++; if (o_miss !== 1'b0 || stb_seen !== 1'b0) begin n_fail++; $display("FAIL mis_bus@%h req %b stb %b want 0 0", addrs[i], o_miss, stb_seen); end
        end
    endtask

    task automatic test_flush();
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        m_clear();
        do_fetch(32'h100, -1, -1, 1'b0);
        n_checks++; if (o_miss !== 1'b1 || o_instr !== e_instr) begin n_fail++; $display("FAIL flush_idle miss %b instr %h want 1 %h", o_miss, o_instr, e_instr); end
        do_fetch(32'h300, -1, 2, 1'b0);
        n_checks++; if (o_valid !== 1'b1 || o_fault !== 1'b0 || o_instr !== e_instr) begin n_fail++; $display("FAIL flush_mid valid %b fault %b instr %h want 1 0 %h", o_valid, o_fault, o_instr, e_instr); end
        do_fetch(32'h304, -1, -1, 1'b0);
        n_checks++; if (o_miss !== 1'b1) begin n_fail++; $display("FAIL flush_mid_refetch got %b want 1", o_miss); end
        do_fetch(32'h304, -1, -1, 1'b1);
        n_checks++; if (o_miss !== 1'b1 || o_instr !== e_instr) begin n_fail++; $display("FAIL flush_with_fetch miss %b instr %h want 1 %h", o_miss, o_instr, e_instr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        do_fetch(32'h100, -1, -1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            a = 32'h100 | (32'($urandom_range(0, 3)) << 2);
            fetch_i = 1'b1; addr_i = a;
            @(negedge clk_i);
            n_checks++; if (valid_o !== 1'b1 || ctrl_req_o !== 1'b0) begin n_fail++; $display("FAIL b2b_valid[%0d] valid %b req %b want 1 0", i, valid_o, ctrl_req_o); end
            n_checks++; if (instruction_o !== mem_word(word_of(a))) begin n_fail++; $display("FAIL b2b_instr[%0d] got %h want %h", i, instruction_o, mem_word(word_of(a))); end
        end
        fetch_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end got %b want 0", valid_o); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int eb, fb;
        bit fw;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom & 32'hFFC0_0000) | (32'($urandom_range(0, 3)) << 6)
              | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 15) == 0) a = a | 32'($urandom_range(1, 3));
            eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            fw = ($urandom_range(0, 15) == 0);
            do_fetch(a, eb, fb, fw);
            n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_valid[%0d]@%h got %b want 1", i, a, o_valid); end
            n_checks++; if (o_miss !== e_miss) begin n_fail++; $display("FAIL rnd_miss[%0d]@%h got %b want %b", i, a, o_miss, e_miss); end
            n_checks++; if (o_fault !== e_fault) begin n_fail++; $display("FAIL rnd_fault[%0d]@%h got %b want %b", i, a, o_fault, e_fault); end
            if (!e_fault) begin
                n_checks++; if (o_instr !== e_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]@%h got %h want %h", i, a, o_instr, e_instr); end
            end
            if (e_miss && !e_err) begin
                n_checks++; if (adr_log.size() != 4 || adr_log[0] !== {10'b0, a[21:4], 2'b00}) begin n_fail++; $display("FAIL rnd_adr[%0d]@%h beats %0d", i, a, adr_log.size()); end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        fetch_i = 1'b1; addr_i = 32'h3C0;
        @(negedge clk_i);
        fetch_i = 1'b0;
        n_checks++; if (ctrl_req_o !== 1'b1) begin n_fail++; $display("FAIL rmf_req got %b want 1", ctrl_req_o); end
        ctrl_grant_i = 1'b1;
        @(negedge clk_i);
        n_checks++; if (cyc_o !== 1'b1) begin n_fail++; $display("FAIL rmf_cyc got %b want 1", cyc_o); end
        master_dat_i = 32'hDEAD_BEEF; ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        n_checks++; if ({cyc_o, stb_o, ctrl_req_o, busy_o} !== 4'b0000) begin n_fail++; $display("FAIL rmf_async cyc/stb/req/busy got %b want 0000", {cyc_o, stb_o, ctrl_req_o, busy_o}); end
        @(negedge clk_i);
        reset_i = 1'b0; ctrl_grant_i = 1'b0;
        m_reset();
        @(negedge clk_i);
        do_fetch(32'h3C0, -1, -1, 1'b0);
        n_checks++; if (o_miss !== 1'b1 || o_instr !== e_instr) begin n_fail++; $display("FAIL rmf_refetch miss %b instr %h want 1 %h", o_miss, o_instr, e_instr); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seed = $urandom;
        m_reset();
        test_reset();
        test_cold_miss();
        test_hits();
        test_replacement();
        test_bus_error();
        test_misaligned();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
